// File: rtl/y_adder1_pkg.sv
// Shared definitions for the y_adder1 bit-slice: reset value and the
// packed {cout, z} result pair produced by the full-adder core.
package y_adder1_pkg;

  localparam logic RESET_VAL = 1'b0;

  typedef struct packed {
    logic cout;
    logic z;
  } fa_res_t;

  function automatic fa_res_t fa_eval(input logic a, input logic b, input logic cin);
    fa_res_t r;
    logic    p;
    p      = a ^ b;
    r.z    = p ^ cin;
    r.cout = (a & b) | (cin & p);
    return r;
  endfunction

endpackage

// File: rtl/y_adder1_fa_core.sv
// Purely combinational full adder: {cout, z} = a + b + cin.
module y_adder1_fa_core
  import y_adder1_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic z,
  output logic cout
);

  fa_res_t res;

  always_comb begin
    res  = fa_eval(a, b, cin);
    z    = res.z;
    cout = res.cout;
  end

endmodule

// File: rtl/y_adder1.sv
// Single-bit full adder with combinational outputs plus a one-stage
// registered copy qualified by a valid strobe.
module y_adder1
  import y_adder1_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic in_valid,
  output logic z,
  output logic cout,
  output logic z_q,
  output logic cout_q,
  output logic out_valid
);

  logic sum_q,   sum_d;
  logic carry_q, carry_d;
  logic valid_q, valid_d;

  y_adder1_fa_core u_core (
    .a    (a),
    .b    (b),
    .cin  (cin),
    .z    (z),
    .cout (cout)
  );

  // Valid semantics: in_valid=1 on a rising edge captures the current
  // combinational result and raises out_valid for exactly the next cycle.
  // There is no ready/backpressure; the sum/carry registers hold while idle.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = 1'b0;
    if (in_valid) begin
      sum_d   = z;
      carry_d = cout;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= RESET_VAL;
      carry_q <= RESET_VAL;
      valid_q <= RESET_VAL;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign z_q       = sum_q;
  assign cout_q    = carry_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_y_adder1.sv
// Directed bench for y_adder1: combinational sweep, reset, capture latency,
// back-to-back capture, asynchronous reset and a two-slice ripple chain.
module tb_y_adder1;

  logic clk;
  logic rst_n;
  logic a, b, cin, in_valid;
  logic z, cout, z_q, cout_q, out_valid;

  // two-slice ripple chain
  logic [1:0] ra, rb, rs;
  logic       rcin, rc0, rc1;
  logic [1:0] rzq, rcq, rov;

  int n_cmp;
  int n_err;

  logic [1:0] exp_tbl [8];

  y_adder1 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .z         (z),
    .cout      (cout),
    .z_q       (z_q),
    .cout_q    (cout_q),
    .out_valid (out_valid)
  );

  y_adder1 u_bit0 (
    .clk (clk), .rst_n (rst_n), .a (ra[0]), .b (rb[0]), .cin (rcin),
    .in_valid (1'b0), .z (rs[0]), .cout (rc0),
    .z_q (rzq[0]), .cout_q (rcq[0]), .out_valid (rov[0])
  );

  y_adder1 u_bit1 (
    .clk (clk), .rst_n (rst_n), .a (ra[1]), .b (rb[1]), .cin (rc0),
    .in_valid (1'b0), .z (rs[1]), .cout (rc1),
    .z_q (rzq[1]), .cout_q (rcq[1]), .out_valid (rov[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] abc, input logic v);
    {a, b, cin} = abc;
    in_valid    = v;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    // abc -> {cout,z}
    exp_tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    rst_n = 1'b0;
    drive(3'b111, 1'b1);
    ra = 2'b00; rb = 2'b00; rcin = 1'b0;

    // Combinational sweep (reset held, must not matter)
    for (int i = 0; i < 8; i++) begin
      {a, b, cin} = 3'(i);
      #1;
      check($sformatf("comb_%0d", i), {2'b00, cout, z}, {2'b00, exp_tbl[i]});
    end

    // Reset held across edges with in_valid=1, a=b=cin=1
    drive(3'b111, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("reset_regs", {1'b0, out_valid, cout_q, z_q}, 4'h0);
    check("reset_comb", {2'b00, cout, z}, 4'h3);

    // Release reset, single capture of 110
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b110, 1'b1);
    @(posedge clk); #1;
    check("cap_110", {1'b0, out_valid, cout_q, z_q}, 4'b0110);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_hold", {1'b0, out_valid, cout_q, z_q}, 4'b0010);

    // Back-to-back captures
    @(negedge clk); drive(3'b001, 1'b1);
    @(posedge clk); #1;
    check("b2b_001", {1'b0, out_valid, cout_q, z_q}, 4'b0101);
    @(negedge clk); drive(3'b011, 1'b1);
    @(posedge clk); #1;
    check("b2b_011", {1'b0, out_valid, cout_q, z_q}, 4'b0110);
    @(negedge clk); drive(3'b111, 1'b1);
    @(posedge clk); #1;
    check("b2b_111", {1'b0, out_valid, cout_q, z_q}, 4'b0111);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_regs", {1'b0, out_valid, cout_q, z_q}, 4'h0);
    check("async_rst_comb", {2'b00, cout, z}, 4'h3);

    // Recovery after reset release
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b100, 1'b1);
    @(posedge clk); #1;
    check("recover_100", {1'b0, out_valid, cout_q, z_q}, 4'b0101);
    @(negedge clk);
    in_valid = 1'b0;

    // Ripple chain: 3 + 1 + 0 = 4 -> carry 1, sum 00
    ra = 2'd3; rb = 2'd1; rcin = 1'b0;
    #1;
    check("ripple_3p1", {1'b0, rc1, rs}, 4'b0100);
    // 1 + 1 + 1 = 3 -> carry 0, sum 11
    ra = 2'd1; rb = 2'd1; rcin = 1'b1;
    #1;
    check("ripple_1p1c", {1'b0, rc1, rs}, 4'b0011);
    // 3 + 3 + 1 = 7 -> carry 1, sum 11
    ra = 2'd3; rb = 2'd3; rcin = 1'b1;
    #1;
    check("ripple_3p3c", {1'b0, rc1, rs}, 4'b0111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/y_adder1.md
Name: y_adder1

Overview:
- Single-bit full adder. Computes sum bit z and carry-out cout from a, b, cin.
- Serves as the bit-slice building block for wider ripple-carry adders (yAdder-style chains), with cin fed from the previous slice's cout.
- Combinational sum/carry outputs are available immediately. A registered copy with a valid strobe is provided for pipelined use on the shared clock.

Parameters:
- None. Width is fixed at 1 bit by definition of the block.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- a  input  1  addend bit
- b  input  1  addend bit
- cin  input  1  carry-in
- in_valid  input  1  qualifies a/b/cin for capture into the registered path
- z  output  1  combinational sum bit
- cout  output  1  combinational carry-out
- z_q  output  1  registered sum bit
- cout_q  output  1  registered carry-out
- out_valid  output  1  registered-path valid strobe

Behaviour:
- Combinational path, no clock and no reset dependence:
  - z = a XOR b XOR cin
  - cout = (a AND b) OR (cin AND (a XOR b))
  - Equivalently, {cout,z} = a + b + cin as a 2-bit unsigned sum, range 0..3.
  - Outputs settle within the same delta/timestep as an input change; no latches.
- Truth table, abc -> cout z: 000->00, 001->01, 010->01, 011->10, 100->01, 101->10, 110->10, 111->11.
- X/Z on any input may propagate X to z/cout; there is no X-masking.
- Registered path, on rising clk:
  - If in_valid=1: z_q <= z, cout_q <= cout, out_valid <= 1.
  - If in_valid=0: z_q and cout_q hold their values, out_valid <= 0.
  - Latency is 1 cycle from in_valid to out_valid.
- Reset:
  - rst_n=0 asynchronously forces z_q=0, cout_q=0, out_valid=0, regardless of clk.
  - Deassertion is seen at the next rising edge.
  - Reset asserted mid-operation discards any pending capture.
  - Reset never affects z/cout.
- Simultaneous reset assertion and a clock edge: reset wins.
- Back-to-back in_valid: one result per cycle, no stalls, no backpressure.

Decomposition:
- Shared package: none required. An optional localparam RESET_VAL=1'b0 may live in the common adder package if one exists.
- Sub-module: fa_core, the purely combinational full-adder gates producing z and cout. The top instantiates fa_core and adds the output register stage.

Test Plan:
- Exhaustive combinational sweep over the 8 combinations of a,b,cin, waiting 1 time unit after each -> {cout,z} equals a+b+cin for each entry (e.g. 1,1,1 -> z=1, cout=1; 1,0,1 -> z=0, cout=1).
- Reset: hold rst_n=0 with in_valid=1, a=b=cin=1 across several edges -> z_q=0, cout_q=0, out_valid=0; z=1, cout=1 throughout.
- Capture latency: release reset, apply a=1 b=1 cin=0 in_valid=1 for one cycle -> after next edge z_q=0, cout_q=1, out_valid=1; the following cycle with in_valid=0 -> out_valid=0, z_q/cout_q hold.
- Back-to-back: in_valid=1 with vectors 001, 011, 111 on consecutive cycles -> registered {cout_q,z_q} = 01, 10, 11 on successive cycles, out_valid stays 1.
- Async reset mid-stream: drop rst_n between clock edges while out_valid=1 -> registered outputs clear immediately, without waiting for an edge.
- Ripple chain check: chain two instances cout->cin and drive 2-bit operands 3+1, cin=0 -> sums 00 with final carry 1.
